// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL power-up / recovery sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_e;

  localparam int unsigned DEF_RESET_CYCLES  = 24;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 2400;
  localparam int unsigned DEF_STABLE_CYCLES = 240;
  localparam int unsigned DEF_MAX_RETRIES   = 3;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit above clog2 so the largest load value always fits.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset to zero.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset / lock-qualification sequencer on the free-running reference clock,
// with bounded retries and a sticky fault state.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count
);

  localparam int unsigned CW = cnt_width(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

  localparam logic [CW-1:0] RST_LOAD  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LOAD  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LOAD  = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  logic lock_s;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (clock),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [3:0]    retry_q, retry_d;
  logic          pll_resetb_q, pll_resetb_d;
  logic          sys_reset_n_q, sys_reset_n_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          retry_req;
  logic          entry;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    retry_req = 1'b0;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end

    // The lock timeout keeps running through STABLE so a bouncing lock
    // cannot stretch the window granted after pll_resetb rises.
    if ((state_q == WAIT_LOCK || state_q == STABLE) && tmo_q != '0) begin
      tmo_d = tmo_q - CW'(1);
    end

    case (state_q)
      PLL_RST: begin
        if (cnt_q == '0) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s)              state_d   = STABLE;
        else if (tmo_q == '0)    retry_req = 1'b1;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!lock_s) retry_req = 1'b1;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PLL_RST;
      end
    endcase

    if (retry_req) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 4'd1;
        state_d = PLL_RST;
      end else begin
        state_d = FAULT;
      end
    end

    if (restart) begin
      retry_d = '0;
      state_d = PLL_RST;
    end

    // A restart while already in PLL_RST still counts as a fresh entry.
    entry = (state_d != state_q) || restart;
    if (entry) begin
      case (state_d)
        PLL_RST:   cnt_d = RST_LOAD;
        WAIT_LOCK: cnt_d = TMO_LOAD;
        STABLE:    cnt_d = STB_LOAD;
        default:   cnt_d = '0;
      endcase
    end

    if (state_q == PLL_RST && state_d == WAIT_LOCK) begin
      tmo_d = TMO_LOAD;
    end

    pll_resetb_d  = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
    sys_reset_n_d = (state_d == RUN);
    ready_d       = (state_d == RUN);
    fault_d       = (state_d == FAULT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= PLL_RST;
      cnt_q         <= RST_LOAD;
      tmo_q         <= '0;
      retry_q       <= '0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      pll_resetb_q  <= pll_resetb_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with short timing parameters.
module tb_pll_reset_seq;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;

  int n_assert = 0;
  int n_fail   = 0;
  int lowcnt;

  pll_reset_seq #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .restart     (restart),
    .pll_resetb  (pll_resetb),
    .sys_reset_n (sys_reset_n),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    step(3);
    check("rst_pll_resetb",  {7'd0, pll_resetb},  8'd0);
    check("rst_sys_reset_n", {7'd0, sys_reset_n}, 8'd0);
    check("rst_ready",       {7'd0, ready},       8'd0);
    check("rst_fault",       {7'd0, fault},       8'd0);
    check("rst_retry",       {4'd0, retry_count}, 8'd0);

    // Clean bring-up
    reset_n = 1'b1;
    lowcnt  = 0;
    while (pll_resetb !== 1'b1 && lowcnt < 100) begin
      lowcnt++;
      step(1);
    end
    check("bringup_rst_len", 8'(lowcnt), 8'd4);
    step(10);
    pll_locked = 1'b1;
    step(10);
    check("bringup_sys_early",   {7'd0, sys_reset_n}, 8'd0);
    check("bringup_ready_early", {7'd0, ready},       8'd0);
    step(1);
    check("bringup_sys",   {7'd0, sys_reset_n}, 8'd1);
    check("bringup_ready", {7'd0, ready},       8'd1);
    check("bringup_retry", {4'd0, retry_count}, 8'd0);
    check("bringup_fault", {7'd0, fault},       8'd0);

    // Lock loss in RUN, then relock
    pll_locked = 1'b0;
    step(2);
    check("loss_sys_still_high", {7'd0, sys_reset_n}, 8'd1);
    step(1);
    check("loss_sys",        {7'd0, sys_reset_n}, 8'd0);
    check("loss_pll_resetb", {7'd0, pll_resetb},  8'd0);
    check("loss_ready",      {7'd0, ready},       8'd0);
    check("loss_retry",      {4'd0, retry_count}, 8'd1);
    pll_locked = 1'b1;
    step(12);
    check("relock_ready_early", {7'd0, ready}, 8'd0);
    step(1);
    check("relock_ready", {7'd0, ready},       8'd1);
    check("relock_retry", {4'd0, retry_count}, 8'd0);

    // Restart in the same cycle the lock loss reaches the FSM
    pll_locked = 1'b0;
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("rs_loss_retry",      {4'd0, retry_count}, 8'd0);
    check("rs_loss_pll_resetb", {7'd0, pll_resetb},  8'd0);
    check("rs_loss_sys",        {7'd0, sys_reset_n}, 8'd0);

    // Timeout retries into FAULT with lock held low
    step(3);
    check("tmo_rst0_low",  {7'd0, pll_resetb}, 8'd0);
    step(1);
    check("tmo_rst0_high", {7'd0, pll_resetb}, 8'd1);
    step(19);
    check("tmo_wait0_end", {7'd0, pll_resetb}, 8'd1);
    step(1);
    check("tmo_rst1_low",  {7'd0, pll_resetb}, 8'd0);
    check("tmo_retry1",    {4'd0, retry_count}, 8'd1);
    step(23);
    check("tmo_wait1_end", {7'd0, pll_resetb}, 8'd1);
    check("tmo_retry1_hold", {4'd0, retry_count}, 8'd1);
    step(1);
    check("tmo_rst2_low",  {7'd0, pll_resetb}, 8'd0);
    check("tmo_retry2",    {4'd0, retry_count}, 8'd2);
    step(23);
    check("tmo_wait2_end", {7'd0, pll_resetb}, 8'd1);
    check("tmo_no_fault_yet", {7'd0, fault},   8'd0);
    step(1);
    check("fault_set",        {7'd0, fault},       8'd1);
    check("fault_pll_resetb", {7'd0, pll_resetb},  8'd0);
    check("fault_sys",        {7'd0, sys_reset_n}, 8'd0);
    check("fault_retry",      {4'd0, retry_count}, 8'd2);
    step(30);
    check("fault_sticky",      {7'd0, fault},       8'd1);
    check("fault_pll_hold",    {7'd0, pll_resetb},  8'd0);
    check("fault_sys_hold",    {7'd0, sys_reset_n}, 8'd0);

    // Restart out of FAULT
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("rs_fault_clear", {7'd0, fault},       8'd0);
    check("rs_fault_pll",   {7'd0, pll_resetb},  8'd0);
    check("rs_fault_retry", {4'd0, retry_count}, 8'd0);
    step(3);
    check("rs_pulse_low",  {7'd0, pll_resetb}, 8'd0);
    step(1);
    check("rs_pulse_high", {7'd0, pll_resetb}, 8'd1);

    // Lock bounce then relock
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    step(2);
    check("bounce_sys_low_a", {7'd0, sys_reset_n}, 8'd0);
    step(8);
    check("bounce_sys_low_b", {7'd0, sys_reset_n}, 8'd0);
    step(1);
    check("bounce_sys_high", {7'd0, sys_reset_n}, 8'd1);
    check("bounce_retry",    {4'd0, retry_count}, 8'd0);

    // Lock bounce then lock stays low: timeout window is not restarted
    restart    = 1'b1;
    pll_locked = 1'b0;
    step(1);
    restart = 1'b0;
    step(4);
    check("bt_wait_entry", {7'd0, pll_resetb}, 8'd1);
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(14);
    check("bt_pll_before_tmo", {7'd0, pll_resetb},  8'd1);
    check("bt_sys_low",        {7'd0, sys_reset_n}, 8'd0);
    step(1);
    check("bt_pll_at_tmo", {7'd0, pll_resetb},  8'd0);
    check("bt_retry",      {4'd0, retry_count}, 8'd1);

    // Asynchronous reset in the middle of STABLE
    pll_locked = 1'b1;
    step(6);
    check("stable_pll_high", {7'd0, pll_resetb},  8'd1);
    check("stable_sys_low",  {7'd0, sys_reset_n}, 8'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pll",   {7'd0, pll_resetb},  8'd0);
    check("async_rst_sys",   {7'd0, sys_reset_n}, 8'd0);
    check("async_rst_ready", {7'd0, ready},       8'd0);
    check("async_rst_fault", {7'd0, fault},       8'd0);
    check("async_rst_retry", {4'd0, retry_count}, 8'd0);
    step(2);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Power-up and recovery sequencer for the 66 MHz system PLL. It runs on the free-running 24 MHz board reference clock and drives the PLL reset pin. It qualifies the asynchronous lock indication and releases the system reset only after lock has been stable for a programmed time. On loss of lock it re-asserts system reset and restarts the PLL, with a bounded retry count and a sticky fault output.

## Interface
Parameters:
- RESET_CYCLES, 24: cycles PLL reset is held low per attempt (1 µs at 24 MHz); ≥ 2.
- LOCK_TIMEOUT, 2400: cycles allowed for synchronized lock to rise after reset release (100 µs); ≥ 2.
- STABLE_CYCLES, 240: cycles synchronized lock must stay continuously high before system reset is released (10 µs); ≥ 2.
- MAX_RETRIES, 3: restart attempts before entering FAULT; 1..15.

Ports:
- clock, in, 1: 24 MHz reference clock, free-running, never PLL-derived.
- reset_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL lock, asynchronous to clock.
- restart, in, 1: synchronous one-cycle request to re-run the sequence.
- pll_resetb, out, 1: to PLL RESETB (active-low).
- sys_reset_n, out, 1: system reset request (active-low); resynchronized into the 66 MHz domain downstream.
- ready, out, 1: high exactly while in RUN.
- fault, out, 1: sticky high in FAULT.
- retry_count, out, 4: attempts consumed since the last success or reset.

## Operation
- pll_locked passes through a 2-flop synchronizer (reset to 0) → lock_s. All decisions use lock_s only.
- One down-counter, width clog2 of the largest timing parameter plus 1, is reloaded on every state entry.
- PLL_RST: pll_resetb=0 for RESET_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: pll_resetb=1.
  - lock_s=1 → STABLE.
  - Counter expiry with lock_s=0 → retry.
- STABLE: lock_s must stay 1 for STABLE_CYCLES consecutive cycles → RUN, and retry_count clears to 0.
  - lock_s=0 at any point → back to WAIT_LOCK. The WAIT_LOCK timeout does not restart; a second, independent down-counter tracks the remaining timeout across STABLE.
- RUN: sys_reset_n=1, ready=1.
  - lock_s=0 → retry.
- Retry rule:
  - If retry_count < MAX_RETRIES: increment retry_count, go to PLL_RST.
  - Otherwise go to FAULT.
  - Lock loss from RUN always counts as an attempt.
- FAULT: pll_resetb=0, sys_reset_n=0, fault=1. Exited only by reset_n or restart.
- restart: accepted in any state.
  - Clears retry_count and fault, goes to PLL_RST.
  - Restart wins over a simultaneous lock-loss or timeout event in the same cycle.
- sys_reset_n=0 in every state except RUN.

## Timing
- Reset values: pll_resetb=0, sys_reset_n=0, ready=0, fault=0, retry_count=0, state=PLL_RST, sync flops=0.
- First sequence starts on the first clock edge after reset_n deasserts.
- All outputs are registered; they change one edge after the state transition decision.
- Lock latency:
  - pll_locked rise to STABLE entry: 2–3 cycles.
  - pll_locked rise to sys_reset_n=1: ≤ 3 + STABLE_CYCLES cycles.
- Lock-loss reaction: pll_locked fall in RUN to sys_reset_n=0 in ≤ 3 cycles; pll_resetb goes low in the same cycle.
- PLL_RST holds pll_resetb=0 for exactly RESET_CYCLES cycles.
- LOCK_TIMEOUT is measured from the cycle pll_resetb rises.
- A glitch on pll_locked shorter than one clock may be missed; this is acceptable.
- reset_n assertion mid-sequence forces reset values asynchronously.

## Structure
- Package pll_seq_pkg holds:
  - state enum {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT};
  - default timing constants;
  - a clog2-based counter-width function.
- Sub-module sync2 (generic 2-flop synchronizer with async active-low reset), reused elsewhere for CDC.
- Core FSM, counters and retry logic live in one module, roughly 150–250 lines.

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean bring-up: release reset_n, raise pll_locked 10 cycles after pll_resetb rises → pll_resetb low exactly 4 cycles; sys_reset_n and ready rise 10–11 cycles after the lock edge; retry_count=0.
- Lock bounce: pll_locked high 5 cycles, low 2, then high → re-enters STABLE; sys_reset_n rises ≥ 8 cycles after the final rise; timeout not extended beyond 20 cycles total.
- Timeout and fault: pll_locked held 0 → three PLL_RST pulses (retry_count 0→1→2), then fault=1 with pll_resetb and sys_reset_n low and constant.
- Lock loss in RUN: drop pll_locked → sys_reset_n=0 within 3 cycles, retry_count=1; relock → RUN and retry_count=0.
- Restart and reset: pulse restart in FAULT → fault clears and a new 4-cycle reset pulse follows. Pulse restart in the same cycle as lock loss in RUN → retry_count=0. Assert reset_n mid-STABLE → all outputs at reset values immediately.
